// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_sequencer
//  Description : Multi-cycle controller for the shared 8-bit ALU. Accepts one
//                instruction per handshake, drives the external ALU from a
//                small register file, captures its result and flags, and
//                writes the result back. Also supports register preloads.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_sequencer #(
  parameter int CMD  = 4,
  parameter int DATA = 8,
  parameter int SH   = 3,
  parameter int NREG = 4,
  parameter int RA   = 2,
  parameter int NOPS = 10
) (
  input  logic            clk,
  input  logic            rst,
  // instruction handshake
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [CMD-1:0]  instr_fs,
  input  logic [RA-1:0]   instr_rd,
  input  logic [RA-1:0]   instr_ra,
  input  logic [RA-1:0]   instr_rb,
  input  logic [SH-1:0]   instr_shift,
  input  logic            instr_wb,
  input  logic [DATA-1:0] instr_port,
  // register preload
  input  logic            ld_valid,
  input  logic [RA-1:0]   ld_addr,
  input  logic [DATA-1:0] ld_data,
  output logic            ld_ack,
  // external ALU
  output logic [CMD-1:0]  alu_fs,
  output logic [DATA-1:0] alu_a,
  output logic [DATA-1:0] alu_b,
  output logic [DATA-1:0] alu_inp,
  output logic [SH-1:0]   alu_shift,
  input  logic [DATA-1:0] alu_out,
  input  logic            alu_n,
  input  logic            alu_z,
  input  logic            alu_c,
  input  logic            alu_v,
  input  logic            alu_d,
  // status
  output logic [4:0]      flags,
  output logic [DATA-1:0] result,
  output logic            done,
  output logic            illegal,
  output logic            busy
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPATCH = 2'd1,
    ST_EXEC     = 2'd2,
    ST_RETIRE   = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Operand/control latches; the alu_* outputs double as the instruction
  // record so fs/shift/port need no separate copy.
  logic [CMD-1:0]  alu_fs_q,    alu_fs_d;
  logic [DATA-1:0] alu_a_q,     alu_a_d;
  logic [DATA-1:0] alu_b_q,     alu_b_d;
  logic [DATA-1:0] alu_inp_q,   alu_inp_d;
  logic [SH-1:0]   alu_shift_q, alu_shift_d;
  logic [RA-1:0]   rd_q,        rd_d;
  logic            wb_q,        wb_d;

  // Result, flags captured in EXEC, and architectural flags updated in RETIRE.
  logic [DATA-1:0] result_q,    result_d;
  logic [4:0]      cap_flags_q, cap_flags_d;
  logic [4:0]      flags_q,     flags_d;
  logic            ld_ack_q,    ld_ack_d;

  logic [DATA-1:0] regs_q [NREG];
  logic [DATA-1:0] regs_d [NREG];

  logic accept;
  logic preload;
  logic fs_illegal;

  // Handshake, preload qualification and legality of the latched opcode.
  always_comb begin
    instr_ready = (state_q == ST_IDLE) && !rst;
    accept      = instr_valid && instr_ready;
    // An offered instruction always wins over a preload in the same cycle.
    preload     = (state_q == ST_IDLE) && !instr_valid && ld_valid;
    fs_illegal  = int'(alu_fs_q) >= NOPS;
  end

  // Next-state logic: fixed four-phase sequence, leaving IDLE only on accept.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (accept) state_d = ST_DISPATCH;
      ST_DISPATCH: state_d = ST_EXEC;
      ST_EXEC:     state_d = ST_RETIRE;
      ST_RETIRE:   state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: operand latch, result/flag capture, writeback, preload.
  always_comb begin
    alu_fs_d    = alu_fs_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_inp_d   = alu_inp_q;
    alu_shift_d = alu_shift_q;
    rd_d        = rd_q;
    wb_d        = wb_q;
    result_d    = result_q;
    cap_flags_d = cap_flags_q;
    flags_d     = flags_q;
    ld_ack_d    = 1'b0;
    regs_d      = regs_q;

    if (accept) begin
      // Operands read here see pre-edge register contents.
      alu_fs_d    = instr_fs;
      alu_a_d     = regs_q[instr_ra];
      alu_b_d     = regs_q[instr_rb];
      alu_inp_d   = instr_port;
      alu_shift_d = instr_shift;
      rd_d        = instr_rd;
      wb_d        = instr_wb;
    end

    if (preload) begin
      regs_d[ld_addr] = ld_data;
      ld_ack_d        = 1'b1;
    end

    // Illegal opcodes leave result and flags untouched.
    if ((state_q == ST_EXEC) && !fs_illegal) begin
      result_d    = alu_out;
      cap_flags_d = {alu_n, alu_z, alu_c, alu_v, alu_d};
    end

    if ((state_q == ST_RETIRE) && !fs_illegal) begin
      flags_d = cap_flags_q;
      if (wb_q) regs_d[rd_q] = result_q;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Datapath registers; reset aborts any in-flight instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_fs_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_inp_q   <= '0;
      alu_shift_q <= '0;
      rd_q        <= '0;
      wb_q        <= 1'b0;
      result_q    <= '0;
      cap_flags_q <= '0;
      flags_q     <= '0;
      ld_ack_q    <= 1'b0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      alu_fs_q    <= alu_fs_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_inp_q   <= alu_inp_d;
      alu_shift_q <= alu_shift_d;
      rd_q        <= rd_d;
      wb_q        <= wb_d;
      result_q    <= result_d;
      cap_flags_q <= cap_flags_d;
      flags_q     <= flags_d;
      ld_ack_q    <= ld_ack_d;
      for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
    end
  end

  // Output mapping; done/illegal decode directly from the RETIRE state.
  always_comb begin
    alu_fs    = alu_fs_q;
    alu_a     = alu_a_q;
    alu_b     = alu_b_q;
    alu_inp   = alu_inp_q;
    alu_shift = alu_shift_q;
    flags     = flags_q;
    result    = result_q;
    ld_ack    = ld_ack_q;
    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_RETIRE);
    illegal   = (state_q == ST_RETIRE) && fs_illegal;
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_sequencer
//  Description : Self-checking bench for alu_sequencer with an adder ALU stub
//                and a behavioural model of registers, flags and result.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid, instr_ready;
  logic [3:0] instr_fs;
  logic [1:0] instr_rd, instr_ra, instr_rb;
  logic [2:0] instr_shift;
  logic       instr_wb;
  logic [7:0] instr_port;
  logic       ld_valid;
  logic [1:0] ld_addr;
  logic [7:0] ld_data;
  logic       ld_ack;
  logic [3:0] alu_fs;
  logic [7:0] alu_a, alu_b, alu_inp;
  logic [2:0] alu_shift;
  logic [7:0] alu_out;
  logic       alu_n, alu_z, alu_c, alu_v, alu_d;
  logic [4:0] flags;
  logic [7:0] result;
  logic       done, illegal, busy;

  alu_sequencer dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_fs(instr_fs), .instr_rd(instr_rd), .instr_ra(instr_ra),
    .instr_rb(instr_rb), .instr_shift(instr_shift), .instr_wb(instr_wb),
    .instr_port(instr_port),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ack(ld_ack),
    .alu_fs(alu_fs), .alu_a(alu_a), .alu_b(alu_b), .alu_inp(alu_inp),
    .alu_shift(alu_shift), .alu_out(alu_out),
    .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v), .alu_d(alu_d),
    .flags(flags), .result(result), .done(done), .illegal(illegal), .busy(busy)
  );

  always #5 clk = ~clk;

  // ALU stub: plain 8-bit adder with carry/overflow flags.
  logic [8:0] stub_sum;
  assign stub_sum = {1'b0, alu_a} + {1'b0, alu_b};
  assign alu_out  = stub_sum[7:0];
  assign alu_c    = stub_sum[8];
  assign alu_z    = (stub_sum[7:0] == 8'h00);
  assign alu_n    = stub_sum[7];
  assign alu_v    = (alu_a[7] == alu_b[7]) && (stub_sum[7] != alu_a[7]);
  assign alu_d    = 1'b0;

  // Accept-edge monitor for throughput checks.
  int cyc = 0, last_acc = 0, prev_acc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (instr_valid && instr_ready) begin
      prev_acc <= last_acc;
      last_acc <= cyc;
    end
  end

  // Reference model.
  logic [7:0] m_regs [4];
  logic [4:0] m_flags;
  logic [7:0] m_result;

  int n_cmp = 0, n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
    m_flags  = 5'h00;
    m_result = 8'h00;
  endtask

  // Called #1 after a rising edge with the DUT idle.
  task automatic preload(input logic [1:0] addr, input logic [7:0] data);
    instr_valid = 1'b0;
    ld_valid = 1'b1; ld_addr = addr; ld_data = data;
    @(posedge clk); #1;
    m_regs[addr] = data;
    check_eq("ld_ack", ld_ack, 1);
    ld_valid = 1'b0;
    @(posedge clk); #1;
    check_eq("ld_ack_once", ld_ack, 0);
  endtask

  // Issues one instruction and checks every phase; hold keeps instr_valid high.
  task automatic issue(input logic [3:0] fs, input logic [1:0] rd, input logic [1:0] ra,
                       input logic [1:0] rb, input logic [2:0] sh, input logic wb,
                       input logic [7:0] port, input logic hold,
                       input logic ld_too, input logic [1:0] laddr, input logic [7:0] ldat);
    logic [7:0] ea, eb;
    logic [8:0] s;
    logic       legal;
    logic [4:0] ef;
    check_eq("ready_pre", instr_ready, 1);
    instr_valid = 1'b1; instr_fs = fs; instr_rd = rd; instr_ra = ra; instr_rb = rb;
    instr_shift = sh; instr_wb = wb; instr_port = port;
    ld_valid = ld_too; ld_addr = laddr; ld_data = ldat;
    ea = m_regs[ra]; eb = m_regs[rb];
    @(posedge clk); #1;
    check_eq("disp_busy", busy, 1);
    check_eq("disp_ready", instr_ready, 0);
    check_eq("disp_fs", alu_fs, fs);
    check_eq("disp_a", alu_a, ea);
    check_eq("disp_b", alu_b, eb);
    check_eq("disp_shift", alu_shift, sh);
    check_eq("disp_inp", alu_inp, port);
    check_eq("disp_ldack", ld_ack, 0);
    if (!hold) instr_valid = 1'b0;
    ld_valid = 1'b0;
    @(posedge clk); #1;
    check_eq("exec_done", done, 0);
    check_eq("exec_a", alu_a, ea);
    legal = (fs < 4'd10);
    s  = {1'b0, ea} + {1'b0, eb};
    ef = {s[7], s[7:0] == 8'h00, s[8], (ea[7] == eb[7]) && (s[7] != ea[7]), 1'b0};
    if (legal) m_result = s[7:0];
    @(posedge clk); #1;
    check_eq("ret_done", done, 1);
    check_eq("ret_illegal", illegal, !legal);
    check_eq("ret_result", result, m_result);
    check_eq("ret_ready", instr_ready, 0);
    if (legal) begin
      m_flags = ef;
      if (wb) m_regs[rd] = m_result;
    end
    @(posedge clk); #1;
    check_eq("idle_done", done, 0);
    check_eq("idle_illegal", illegal, 0);
    check_eq("idle_flags", flags, m_flags);
    check_eq("idle_ready", instr_ready, 1);
  endtask

  task automatic simple(input logic [3:0] fs, input logic [1:0] rd, input logic [1:0] ra,
                        input logic [1:0] rb, input logic wb);
    issue(fs, rd, ra, rb, 3'd0, wb, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; instr_valid = 1'b0; instr_fs = '0; instr_rd = '0; instr_ra = '0;
    instr_rb = '0; instr_shift = '0; instr_wb = 1'b0; instr_port = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
    model_reset();
    #12;
    check_eq("rst_ready", instr_ready, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_flags", flags, 0);
    check_eq("rst_result", result, 0);
    check_eq("rst_alu_a", alu_a, 0);
    check_eq("rst_done", done, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("rel_ready", instr_ready, 1);

    // 1: preload and first add
    preload(2'd0, 8'h7A);
    preload(2'd1, 8'h52);
    simple(4'd0, 2'd2, 2'd0, 2'd1, 1'b1);
    check_eq("t1_result", result, 8'hCC);
    check_eq("t1_flags", flags, 5'b10010);

    // 2: back-to-back with instr_valid held high
    issue(4'd0, 2'd3, 2'd0, 2'd0, 3'd1, 1'b1, 8'h11, 1'b1, 1'b0, 2'd0, 8'h00);
    issue(4'd2, 2'd1, 2'd2, 2'd3, 3'd2, 1'b1, 8'h22, 1'b0, 1'b0, 2'd0, 8'h00);
    check_eq("b2b_gap", last_acc - prev_acc, 4);

    // 3: illegal opcode
    simple(4'hC, 2'd2, 2'd0, 2'd0, 1'b1);

    // 4: no writeback, flags still update
    simple(4'd1, 2'd0, 2'd3, 2'd3, 1'b0);
    simple(4'd0, 2'd0, 2'd0, 2'd2, 1'b0);
    check_eq("t4_r0", alu_a, 8'h7A);
    check_eq("t3_r2", alu_b, 8'hCC);

    // 6: instruction wins over simultaneous preload
    issue(4'd0, 2'd1, 2'd0, 2'd0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b1, 2'd3, 8'h55);
    check_eq("t6_noack", ld_ack, 0);
    simple(4'd0, 2'd0, 2'd3, 2'd3, 1'b0);

    // randomized mix of preloads and instructions
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0)
        preload(2'($urandom_range(0, 3)), 8'($urandom));
      else
        issue(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
              8'($urandom), 1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              8'($urandom));
    end

    // 5: reset during EXEC
    preload(2'd0, 8'h7A);
    instr_valid = 1'b1; instr_fs = 4'd0; instr_rd = 2'd1; instr_ra = 2'd0; instr_rb = 2'd0;
    instr_wb = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check_eq("mid_alu_a", alu_a, 0);
    check_eq("mid_alu_fs", alu_fs, 0);
    check_eq("mid_result", result, 0);
    check_eq("mid_flags", flags, 0);
    check_eq("mid_done", done, 0);
    check_eq("mid_busy", busy, 0);
    check_eq("mid_ready", instr_ready, 0);
    @(posedge clk); #1;
    check_eq("mid_done2", done, 0);
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    check_eq("mid_rel_ready", instr_ready, 1);
    simple(4'd0, 2'd0, 2'd0, 2'd1, 1'b0);
    simple(4'd0, 2'd0, 2'd2, 2'd3, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Multi-cycle execution controller that sequences the shared 8-bit ALU.
- Owns a small register file (NREG x DATA) and a latched flag register.
- Accepts one ALU instruction per valid/ready handshake and drives the ALU function select, operands and shift amount.
- Captures the ALU result and flags, then writes the result back to the register file.
- Sits between the instruction source (decoder or bench) and the combinational ALU; the ALU instance is external.

Parameters:
- CMD, 4, ALU function-select width.
- DATA, 8, datapath width.
- SH, 3, shift-amount width.
- NREG, 4, register-file depth.
- RA, 2, register address width (log2 NREG).
- NOPS, 10, number of legal FS codes (0..NOPS-1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  controller can accept an instruction.
- instr_fs  in  CMD  ALU function select.
- instr_rd  in  RA  destination register.
- instr_ra  in  RA  operand A register.
- instr_rb  in  RA  operand B register.
- instr_shift  in  SH  shift amount.
- instr_wb  in  1  1 = write the result to rd.
- instr_port  in  DATA  value forwarded to the ALU input port.
- ld_valid  in  1  register preload request.
- ld_addr  in  RA  preload address.
- ld_data  in  DATA  preload data.
- ld_ack  out  1  one-cycle pulse: preload performed.
- alu_fs  out  CMD  to ALU FS.
- alu_a  out  DATA  to ALU A.
- alu_b  out  DATA  to ALU B.
- alu_inp  out  DATA  to ALU inpport.
- alu_shift  out  SH  to ALU shift.
- alu_out  in  DATA  ALU result.
- alu_n, alu_z, alu_c, alu_v, alu_d  in  1 each  ALU flags.
- flags  out  5  latched {N,Z,C,V,D}.
- result  out  DATA  last captured ALU result.
- done  out  1  one-cycle pulse at instruction retire.
- illegal  out  1  one-cycle pulse, coincident with done, when FS >= NOPS.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, while rst=1):
  - State IDLE; all registers, flags, result, alu_* outputs = 0.
  - done, illegal, ld_ack = 0.
  - instr_ready = 0 while rst=1; instr_ready = 1 from the first clk edge after rst falls.
- FSM states: IDLE -> DISPATCH -> EXEC -> RETIRE -> IDLE. No other transitions.
- instr_ready = (state == IDLE) and not rst; combinational from state.
- Accept:
  - Occurs on the edge where instr_valid & instr_ready = 1.
  - fs, rd, wb, shift and port are latched.
  - reg[ra] and reg[rb] are read at that edge. Same-cycle reads see pre-edge contents.
- DISPATCH (1 cycle): alu_fs, alu_a, alu_b, alu_shift and alu_inp are registered outputs, valid for the whole cycle and held stable through EXEC.
- EXEC (1 cycle): at the end of the cycle, alu_out goes to result and alu_{n,z,c,v,d} are captured.
- RETIRE (1 cycle):
  - done = 1.
  - If FS < NOPS: flags update from the captured values. If wb = 1, reg[rd] <= result at the end of the cycle.
  - If FS >= NOPS: illegal = 1; no writeback; flags and result keep their previous values (the EXEC capture is suppressed).
- Latency and throughput:
  - Accept edge T; done is high in cycle T+3; instr_ready returns in cycle T+4.
  - Maximum throughput is one instruction per 4 cycles.
- Read-after-write: the next instruction is accepted no earlier than the edge after RETIRE, so it reads the written value. No bypass is needed.
- rd equal to ra or rb: legal. Operands were latched at accept, so there is no hazard.
- Preload:
  - Performed only in IDLE with instr_valid = 0. reg[ld_addr] <= ld_data at the edge; ld_ack pulses in the following cycle.
  - When instr_valid and ld_valid are both asserted in IDLE, the instruction wins and the preload is ignored (no ld_ack). ld_valid outside IDLE is ignored.
- Outputs and ports:
  - alu_* outputs keep their last values in IDLE; they are not re-zeroed.
  - Registers and flags retain their values across instructions.
  - Instruction inputs are don't-care when instr_valid = 0.
- Reset mid-operation: async rst in any state aborts immediately, with no writeback and no done. All state clears as on reset.
- All arithmetic belongs to the ALU; the sequencer performs no width changes. Address fields wrap naturally (RA bits).

Test Plan:
Bench uses an ALU stub: out = A + B (mod 256), c = carry, z = (out == 0), n = out[7], v = signed overflow, d = 0.
1. Preload r0 = 8'h7A, r1 = 8'h52 -> ld_ack pulses once each. Issue fs=0, ra=0, rb=1, rd=2, wb=1 -> alu_a = 7A and alu_b = 52 in DISPATCH; done at T+3; result = 8'hCC; flags N=1, Z=0, C=0, V=1; r2 = CC.
2. Back-to-back: hold instr_valid high with two instructions -> second accepted exactly 4 cycles after the first; second reads r2 = CC.
3. fs = 4'hC (illegal) -> done and illegal both pulse at T+3; r[rd] and flags unchanged; instr_ready back at T+4.
4. wb = 0, rd = 0 -> flags update, r0 stays 7A.
5. Assert rst during EXEC -> all outputs 0 asynchronously; no done; r0..r3 = 0; instr_ready = 1 one edge after release.
6. ld_valid and instr_valid both high in IDLE -> instruction accepted, no ld_ack, target register unchanged.
